// File: rtl/pipe_word_serializer.sv
// Serializes one {header, payload} PipeIn message into a framed stream of words:
// a header word followed by the payload words (LSW first), with valid/ready flow control.
module pipe_word_serializer #(
    parameter int HDR_W     = 16,
    parameter int PAYLOAD_W = 128,
    parameter int WORD_W    = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       pipe_enq__ENA,
    input  logic [HDR_W+PAYLOAD_W-1:0] pipe_enq_v,
    input  logic                       pipe_enq_last,
    output logic                       pipe_enq__RDY,
    output logic                       word_valid,
    output logic [WORD_W-1:0]          word_data,
    output logic                       word_last,
    input  logic                       word_ready,
    output logic [15:0]                msg_count,
    output logic                       busy
);

    localparam int NW = PAYLOAD_W / WORD_W;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(NW - 1);
    localparam logic [7:0]    NW_BYTE = 8'(NW);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t                     state_reg, state_next;
    logic [KW-1:0]              k_reg, k_next;
    logic [HDR_W+PAYLOAD_W-1:0] msg_reg;
    logic                       last_reg;
    logic [15:0]                msg_count_reg;
    logic                       hs, enq_fire, final_hs;
    logic [WORD_W-1:0]          payload_words [NW];

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_words
            assign payload_words[gi] = msg_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Valid comes only from state, so it never depends on word_ready combinationally.
    assign word_valid = (state_reg != IDLE);
    assign busy       = word_valid;
    assign hs         = word_valid & word_ready;
    assign final_hs   = (state_reg == BODY) && (k_reg == K_LAST) && word_ready;
    // Accepting during the final handshake lets the next frame follow with no bubble.
    assign pipe_enq__RDY = !nRST && ((state_reg == IDLE) || final_hs);
    assign enq_fire      = pipe_enq__ENA & pipe_enq__RDY;
    assign msg_count     = msg_count_reg;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        word_data  = '0;
        word_last  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enq_fire) state_next = HEAD;
            end
            HEAD: begin
                word_data = {last_reg, {(WORD_W-HDR_W-9){1'b0}}, NW_BYTE,
                             msg_reg[HDR_W+PAYLOAD_W-1:PAYLOAD_W]};
                if (hs) begin
                    state_next = BODY;
                    k_next     = '0;
                end
            end
            BODY: begin
                word_data = payload_words[k_reg];
                word_last = (k_reg == K_LAST);
                if (hs) begin
                    if (k_reg == K_LAST) state_next = enq_fire ? HEAD : IDLE;
                    else                 k_next     = k_reg + KW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            msg_reg       <= '0;
            last_reg      <= 1'b0;
            msg_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            if (enq_fire) begin
                msg_reg  <= pipe_enq_v;
                last_reg <= pipe_enq_last;
            end
            if (final_hs) msg_count_reg <= msg_count_reg + 16'd1;
        end
    end

    // An enq while not ready is dropped by the logic above; flag it in simulation.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            assert (!(pipe_enq__ENA && !pipe_enq__RDY))
                else $warning("pipe_word_serializer: enq while not ready ignored");
        end
    end

endmodule

// File: tb/tb_pipe_word_serializer.sv
// Scoreboard bench for pipe_word_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_pipe_word_serializer;

    localparam int HDR_W = 16, PAYLOAD_W = 128, WORD_W = 32, NW = PAYLOAD_W / WORD_W;

    logic                       CLK = 1'b0;
    logic                       nRST, enq_ena, enq_last, word_ready;
    logic [HDR_W+PAYLOAD_W-1:0] enq_v;
    logic                       enq_rdy, word_valid, word_last, busy;
    logic [WORD_W-1:0]          word_data;
    logic [15:0]                msg_count;

    pipe_word_serializer #(.HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .nRST(nRST), .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v),
        .pipe_enq_last(enq_last), .pipe_enq__RDY(enq_rdy), .word_valid(word_valid),
        .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
        .msg_count(msg_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0, n_err = 0;
    logic [32:0] exp_q [$];
    int          words_seen = 0;
    logic [15:0] sb_count = 16'd0;
    bit          stall_pending = 1'b0;
    logic [32:0] stall_word;
    int          ready_mode = 0, pat_idx = 0;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: frame built from the message fields with plain arithmetic.
    task automatic push_model(input logic [15:0] h, input logic [127:0] p, input bit l);
        logic [127:0] sh;
        logic [31:0]  hw;
        hw = (32'(l) << 31) | (32'(NW) << 16) | 32'(h);
        exp_q.push_back({1'b0, hw});
        for (int k = 0; k < NW; k++) begin
            sh = p >> (32 * k);
            exp_q.push_back({(k == NW - 1), sh[31:0]});
        end
    endtask

    task automatic push_test1_words();
        logic [32:0] t [5];
        t = '{{1'b0, 32'h8004_0005}, {1'b0, 32'hBBBB_AAAA}, {1'b0, 32'hDDDD_CCCC},
              {1'b0, 32'h2222_1111}, {1'b1, 32'h4444_3333}};
        for (int i = 0; i < 5; i++) exp_q.push_back(t[i]);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_msg(input logic [15:0] h, input logic [127:0] p, input bit l,
                            input bit push);
        bit ok = 1'b0;
        enq_ena = 1'b1; enq_v = {h, p}; enq_last = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (enq_rdy) begin
                ok = 1'b1;
                if (push) push_model(h, p, l);
            end
            @(posedge CLK); #1;
        end
        enq_ena = 1'b0;
        chk("enq_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        chk("drain_timeout", 64'(ok), 64'd1);
        @(negedge CLK);
        chk("msg_count", 64'(msg_count), 64'(sb_count));
        chk("busy_idle", 64'(busy), 64'd0);
        @(posedge CLK); #1;
    endtask

    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0:       word_ready = 1'b1;
            1: begin word_ready = pat[pat_idx % 6]; pat_idx++; end
            default: word_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: inputs are stable at negedge, so valid&ready here is the coming handshake.
    always @(negedge CLK) begin
        if (nRST) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                chk("stall_valid_held", 64'(word_valid), 64'd1);
                chk("stall_word_stable", 64'({word_last, word_data}), 64'(stall_word));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'({word_last, word_data}), 64'h1_0000_0000_0000);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("word", 64'({word_last, word_data}), 64'(e));
                    words_seen++;
                    if (e[32]) sb_count = sb_count + 16'd1;
                end
                stall_pending = 1'b0;
            end else if (word_valid) begin
                stall_pending = 1'b1;
                stall_word    = {word_last, word_data};
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cnt;
        bit ok;
        nRST = 1'b1; enq_ena = 1'b0; enq_last = 1'b0; enq_v = '0; word_ready = 1'b1;

        // Reset state
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rdy_in_reset", 64'(enq_rdy), 64'd0);
        chk("reset_valid", 64'(word_valid), 64'd0);
        chk("reset_data", 64'(word_data), 64'd0);
        chk("reset_last", 64'(word_last), 64'd0);
        chk("reset_count", 64'(msg_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge CLK); #1; nRST = 1'b0;
        @(negedge CLK);
        chk("rdy_after_reset", 64'(enq_rdy), 64'd1);
        @(posedge CLK); #1;

        // Test 1: single message, constant expected words, latency N+1
        push_test1_words();
        send_msg(16'h0005, 128'h44443333_22221111_DDDDCCCC_BBBBAAAA, 1'b1, 1'b0);
        @(negedge CLK);
        chk("header_latency", 64'(word_valid), 64'd1);
        @(posedge CLK); #1;
        drain();
        chk("t1_count", 64'(msg_count), 64'd1);

        // Test 2: back-to-back, no bubble between frames
        fork
            begin
                send_msg(16'h1234, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
                send_msg(16'hBEEF, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
            end
            begin
                ok = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge CLK);
                    if (word_valid) begin ok = 1'b1; break; end
                end
                chk("b2b_start_timeout", 64'(ok), 64'd1);
                cnt = ok ? 1 : 0;
                repeat (9) begin
                    @(negedge CLK);
                    if (word_valid) cnt++;
                end
                chk("b2b_valid_cycles", 64'(cnt), 64'd10);
            end
        join
        drain();

        // Test 3: stall pattern 1,0,0,1,0,1 ... same words as test 1
        ready_mode = 1; pat_idx = 0;
        push_test1_words();
        send_msg(16'h0005, 128'h44443333_22221111_DDDDCCCC_BBBBAAAA, 1'b1, 1'b0);
        drain();
        ready_mode = 0;

        // Test 4: enq mid-frame is ignored
        send_msg(16'h0A0A, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        @(posedge CLK); #1;
        enq_ena = 1'b1; enq_v = {$urandom, $urandom, $urandom, $urandom, $urandom}; enq_last = 1'b1;
        @(negedge CLK);
        chk("midframe_rdy", 64'(enq_rdy), 64'd0);
        @(posedge CLK); #1;
        enq_ena = 1'b0;
        drain();

        // Test 5: reset after two payload words
        base = words_seen;
        send_msg(16'h0505, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (words_seen >= base + 3) begin ok = 1'b1; break; end
            @(posedge CLK); #1;
        end
        chk("t5_wait_timeout", 64'(ok), 64'd1);
        nRST = 1'b1;
        @(negedge CLK);
        chk("t5_rdy_in_reset", 64'(enq_rdy), 64'd0);
        @(posedge CLK); #1;
        nRST = 1'b0;
        exp_q.delete();
        sb_count = 16'd0;
        @(negedge CLK);
        chk("t5_valid", 64'(word_valid), 64'd0);
        chk("t5_count", 64'(msg_count), 64'd0);
        chk("t5_rdy", 64'(enq_rdy), 64'd1);
        @(posedge CLK); #1;
        send_msg(16'h0606, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
        drain();

        // Randomized traffic with random ready and idle gaps
        ready_mode = 2;
        for (int m = 0; m < 20; m++) begin
            send_msg(16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        end
        drain();
        ready_mode = 0;

        // Test 6: msg_count wraps
        force dut.msg_count_reg = 16'hFFFF;
        @(posedge CLK); #1;
        release dut.msg_count_reg;
        sb_count = 16'hFFFF;
        @(negedge CLK);
        chk("t6_preload", 64'(msg_count), 64'hFFFF);
        @(posedge CLK); #1;
        send_msg(16'h0707, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        drain();
        chk("t6_wrap", 64'(msg_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
